// File: rtl/uart_pkt_pkg.sv
// Shared state encoding, default framing bytes and packet-length helper
// for the UART packet sequencer.
package uart_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } pkt_state_t;

   localparam logic [7:0] DEF_HEADER  = 8'hAA;
   localparam logic [7:0] DEF_TRAILER = 8'h55;

   // Bytes on the wire: header + 2 per word + optional checksum + trailer.
   function automatic int pkt_len(input int num_words, input bit chksum_en);
      return 2 * num_words + 2 + (chksum_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/uart_pkt_byte_sel.sv
// Combinational byte-index to wire-byte mux: header, payload MSB-first,
// optional checksum (UART_PKT_CHKSUM_EN) and trailer.
module uart_pkt_byte_sel
   import uart_pkt_pkg::*;
#(
   parameter int         NUM_WORDS = 4,
   parameter logic [7:0] HEADER    = DEF_HEADER,
   parameter logic [7:0] TRAILER   = DEF_TRAILER,
   parameter int         IDX_W     = 4
) (
   input  logic [IDX_W-1:0]         idx,
   input  logic [16*NUM_WORDS-1:0]  pkt_data,
`ifdef UART_PKT_CHKSUM_EN
   input  logic [7:0]               chksum,
`endif
   output logic [7:0]               tx_byte
);

   always_comb begin
      tx_byte = TRAILER;
      if (idx == '0)
         tx_byte = HEADER;
      // Payload byte b (b = idx-1): even b is the high byte of word b/2.
      for (int b = 0; b < 2 * NUM_WORDS; b++) begin
         if (idx == IDX_W'(b + 1))
            tx_byte = pkt_data[16 * (b / 2) + 8 * (1 - b % 2) +: 8];
      end
`ifdef UART_PKT_CHKSUM_EN
      if (idx == IDX_W'(2 * NUM_WORDS + 1))
         tx_byte = chksum;
`endif
   end

endmodule

// File: rtl/uart_pkt_sched.sv
// Packet sequencer feeding the byte-level UART transmitter one byte per handshake.
// Define UART_PKT_CHKSUM_EN to insert a mod-256 payload checksum before the trailer.
module uart_pkt_sched
   import uart_pkt_pkg::*;
#(
   parameter int         NUM_WORDS    = 4,
   parameter logic [7:0] HEADER       = DEF_HEADER,
   parameter logic [7:0] TRAILER      = DEF_TRAILER,
   parameter int         TIMEOUT_CLKS = 8192
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     i_Pkt_Valid,
   input  logic [16*NUM_WORDS-1:0]  i_Pkt_Data,
   output logic                     o_Pkt_Ready,
   output logic                     o_Tx_DV,
   output logic [7:0]               o_Tx_Byte,
   input  logic                     i_Tx_Active,
   input  logic                     i_Tx_Done,
   output logic                     o_Busy,
   output logic                     o_Timeout,
   output logic [15:0]              o_Pkt_Count
);

`ifdef UART_PKT_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int               PKT_LEN  = pkt_len(NUM_WORDS, CHK_EN);
   localparam int               IDX_W    = $clog2(PKT_LEN + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
   localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CLKS - 1);

   pkt_state_t              state;
   logic [IDX_W-1:0]        idx;
   logic [16*NUM_WORDS-1:0] pkt_data_p0;
   logic                    tx_done_p1;
   logic [15:0]             tmo_cnt;
   logic [7:0]              sel_byte;
   logic                    done_rise;
   logic                    issue_go;
   logic                    accept;

   assign accept    = (state == ST_IDLE) && i_Pkt_Valid && o_Pkt_Ready;
   assign issue_go  = (state == ST_ISSUE) && !i_Tx_Active && !i_Tx_Done;
   assign done_rise = i_Tx_Done && !tx_done_p1;

`ifdef UART_PKT_CHKSUM_EN
   logic [7:0] chksum;
   logic       is_payload;

   function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   assign is_payload = (idx != '0) && (idx <= IDX_W'(2 * NUM_WORDS));
`endif

   uart_pkt_byte_sel #(
      .NUM_WORDS (NUM_WORDS),
      .HEADER    (HEADER),
      .TRAILER   (TRAILER),
      .IDX_W     (IDX_W)
   ) u_byte_sel (
      .idx      (idx),
      .pkt_data (pkt_data_p0),
`ifdef UART_PKT_CHKSUM_EN
      .chksum   (chksum),
`endif
      .tx_byte  (sel_byte)
   );

   // p0: packet payload and running checksum, captured without reset
   always_ff @(posedge i_Clock) begin
      if (accept)
         pkt_data_p0 <= i_Pkt_Data;
`ifdef UART_PKT_CHKSUM_EN
      if (state == ST_IDLE)
         chksum <= '0;
      else if (issue_go && is_payload)
         chksum <= chk_add(chksum, sel_byte);
`endif
   end

   // p1: sequencing FSM, done-edge history and byte timeout
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         tx_done_p1  <= 1'b0;
         tmo_cnt     <= '0;
         o_Pkt_Ready <= 1'b1;
         o_Tx_DV     <= 1'b0;
         o_Tx_Byte   <= '0;
         o_Busy      <= 1'b0;
         o_Timeout   <= 1'b0;
         o_Pkt_Count <= '0;
      end else begin
         tx_done_p1 <= i_Tx_Done;
         o_Tx_DV    <= 1'b0;
         o_Timeout  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  idx         <= '0;
                  state       <= ST_ISSUE;
                  o_Pkt_Ready <= 1'b0;
                  o_Busy      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (issue_go) begin
                  o_Tx_DV   <= 1'b1;
                  o_Tx_Byte <= sel_byte;
                  tmo_cnt   <= '0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A done pulse wins over a timeout landing on the same cycle.
               if (done_rise) begin
                  idx   <= idx + 1'b1;
                  state <= (idx == LAST_IDX) ? ST_DONE : ST_ISSUE;
               end else if (tmo_cnt == TMO_LAST) begin
                  o_Timeout   <= 1'b1;
                  state       <= ST_IDLE;
                  o_Pkt_Ready <= 1'b1;
                  o_Busy      <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            ST_DONE: begin
               o_Pkt_Count <= o_Pkt_Count + 16'd1;
               state       <= ST_IDLE;
               o_Pkt_Ready <= 1'b1;
               o_Busy      <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_pkt_sched.sv
// Self-checking bench for uart_pkt_sched with a 10-cycle-per-byte transmitter model.
// Follows UART_PKT_CHKSUM_EN to decide whether the checksum byte is expected.
module tb_uart_pkt_sched;

   localparam int         NW  = 2;
   localparam int         TMO = 64;
   localparam logic [7:0] HDR = 8'hAA;
   localparam logic [7:0] TRL = 8'h55;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] data  = '0;
   logic        ready, dv, busy, tmo;
   logic [7:0]  txb;
   logic [15:0] count;

   // transmitter model state
   logic        tx_active  = 1'b0;
   logic        tx_done;
   logic        tx_hang    = 1'b0;
   logic        tx_abort   = 1'b0;
   int          tx_timer   = 0;
   int          done_timer = 0;
   logic [7:0]  cur_byte   = '0;

   // monitors
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          cyc = 0, dv_cyc = 0, tmo_cyc = 0, dv_total = 0, tmo_pulses = 0;
   int          acc_cnt = 0, idle_cyc = 0;
   logic        stable_err = 1'b0, rb_err = 1'b0, viol = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign tx_done = (done_timer != 0);

   uart_pkt_sched #(
      .NUM_WORDS    (NW),
      .HEADER       (HDR),
      .TRAILER      (TRL),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Pkt_Valid (valid),
      .i_Pkt_Data  (data),
      .o_Pkt_Ready (ready),
      .o_Tx_DV     (dv),
      .o_Tx_Byte   (txb),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done),
      .o_Busy      (busy),
      .o_Timeout   (tmo),
      .o_Pkt_Count (count)
   );

   // Transmitter model (no reset, like the real one) plus protocol monitors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dv) begin
         rx_q.push_back(txb);
         dv_total <= dv_total + 1;
         dv_cyc   <= cyc;
         if (tx_active || tx_done) viol <= 1'b1;
         cur_byte  <= txb;
         tx_abort  <= 1'b0;
         tx_active <= 1'b1;
         tx_timer  <= 10;
      end else if (tx_timer > 0) begin
         tx_timer <= tx_timer - 1;
         if (tx_timer == 1) begin
            tx_active <= 1'b0;
            if (!tx_hang) done_timer <= 2;
         end
      end
      if (done_timer > 0) done_timer <= done_timer - 1;
      if (tx_active && !tx_abort && txb !== cur_byte) stable_err <= 1'b1;
      if (rst && tx_active) tx_abort <= 1'b1;
      if (tmo) begin
         tmo_cyc    <= cyc;
         tmo_pulses <= tmo_pulses + 1;
      end
      if (!rst && ready !== !busy) rb_err <= 1'b1;
      if (!rst && !busy) idle_cyc <= idle_cyc + 1;
      if (valid && ready && !rst) acc_cnt <= acc_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference framing: header, each word high byte then low byte, optional sum, trailer.
   task automatic add_exp(input logic [31:0] d);
      int         s;
      logic [15:0] w;
      s = 0;
      exp_q.push_back(HDR);
      for (int k = 0; k < NW; k++) begin
         w = d[16*k +: 16];
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
         s = s + int'(w[15:8]) + int'(w[7:0]);
      end
`ifdef UART_PKT_CHKSUM_EN
      exp_q.push_back(8'(s));
`endif
      exp_q.push_back(TRL);
   endtask

   task automatic cmp_bytes(input string tag);
      logic [7:0] obs;
      chk({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         chk($sformatf("%s_b%0d", tag, i), obs, exp_q[i]);
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic send(input logic [31:0] d);
      int n;
      n = 0;
      while (!ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", ready, 1);
      valid = 1'b1;
      data  = d;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [31:0] d;
      int          n, c0, a0, i0, b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_dv", dv, 0);
      chk("rst_byte", txb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      @(negedge clk);

      // directed packet
      add_exp(32'h1234_ABCD);
      send(32'h1234_ABCD);
      wait_idle("pkt1");
      cmp_bytes("pkt1");
      chk("pkt1_count", count, 1);

      // random single packets
      for (int p = 0; p < 3; p++) begin
         d = $urandom();
         add_exp(d);
         send(d);
         wait_idle($sformatf("rnd%0d", p));
         cmp_bytes($sformatf("rnd%0d", p));
      end
      chk("rnd_count", count, 4);

      // valid held high: three frames back to back, one idle cycle between
      d  = $urandom();
      for (int p = 0; p < 3; p++) add_exp(d);
      c0 = int'(count);
      a0 = acc_cnt;
      i0 = idle_cyc;
      valid = 1'b1;
      data  = d;
      n = 0;
      while (int'(count) != c0 + 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      valid = 1'b0;
      chk("b2b_count", count, 7);
      chk("b2b_accepts", acc_cnt - a0, 3);
      chk("b2b_idle_cycles", idle_cyc - i0, 3);
      cmp_bytes("b2b");

      // transmitter never signals done: byte timeout
      tx_hang = 1'b1;
      c0 = int'(count);
      b0 = tmo_pulses;
      send($urandom());
      n = 0;
      while (!tmo && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_pulse", tmo, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_ready", ready, 1);
      chk("tmo_count", count, c0);
      @(negedge clk);
      chk("tmo_one_cycle", tmo, 0);
      chk("tmo_delay", tmo_cyc - dv_cyc, TMO);
      chk("tmo_pulses", tmo_pulses - b0, 1);
      chk("tmo_nbytes", rx_q.size(), 1);
      chk("tmo_hdr", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, HDR);
      rx_q.delete();
      tx_hang = 1'b0;
      repeat (15) @(negedge clk);

      // reset after the third byte of a packet
      b0 = dv_total;
      send($urandom());
      n = 0;
      while (dv_total < b0 + 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_third_dv", dv_total, b0 + 3);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_ready", ready, 1);
      chk("mid_dv", dv, 0);
      chk("mid_byte", txb, 0);
      chk("mid_busy", busy, 0);
      chk("mid_tmo", tmo, 0);
      chk("mid_count", count, 0);
      rst = 1'b0;
      rx_q.delete();
      d = $urandom();
      add_exp(d);
      send(d);
      wait_idle("post_rst");
      cmp_bytes("post_rst");
      chk("post_rst_count", count, 1);

      // counter wrap
      force dut.o_Pkt_Count = 16'hFFFF;
      @(negedge clk);
      release dut.o_Pkt_Count;
      @(negedge clk);
      chk("wrap_pre", count, 16'hFFFF);
      d = $urandom();
      add_exp(d);
      send(d);
      wait_idle("wrap");
      cmp_bytes("wrap");
      chk("wrap_count", count, 0);

      // whole-run protocol monitors
      chk("byte_stable", stable_err, 0);
      chk("ready_not_busy", rb_err, 0);
      chk("dv_while_tx_busy", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
